// File: rtl/efx_serdes_pkg.sv
// ---------------------------------------------------------------------------
// efx_serdes_pkg
// Shared types and helpers for the DDR output serializer.
//   ser_state_t : serializer control state (idle / running)
//   beats_of    : bit pairs per word (RATIO/2)
//   beat_width  : width of the beat counter
//   lane_base   : bit offset of a lane inside the flattened parallel word
//   bit_index   : which word bit is sent for a given beat and half-cycle
// ---------------------------------------------------------------------------
package efx_serdes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ser_state_t;

    function automatic int beats_of(input int ratio);
        return ratio / 2;
    endfunction

    function automatic int beat_width(input int ratio);
        return (ratio / 2 > 1) ? $clog2(ratio / 2) : 1;
    endfunction

    function automatic int lane_base(input int lane, input int ratio);
        return lane * ratio;
    endfunction

    // half = 0 is the high-phase (even) bit, half = 1 the low-phase (odd) bit.
    function automatic int bit_index(input int beat, input int half,
                                     input bit msb_first, input int ratio);
        int pos;
        pos = 2 * beat + half;
        return msb_first ? (ratio - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/efx_oserdes_ddr_if.sv
// ---------------------------------------------------------------------------
// efx_oserdes_ddr_if
// Parallel word handshake plus serial outputs and status of the serializer.
//   DATA_IN    : LANES*RATIO bits, lane l at [l*RATIO +: RATIO]
//   DATA_VALID : source has a word on DATA_IN
//   DATA_READY : serializer holding buffer is empty
//   Q          : DDR serial output per lane
//   BUSY       : serializer running
//   UNDERRUN   : one-cycle pulse when the stream ran dry after a word
// master = word source, slave = serializer.
// ---------------------------------------------------------------------------
interface efx_oserdes_ddr_if #(
    parameter int LANES = 4,
    parameter int RATIO = 8
);
    logic [LANES*RATIO-1:0] DATA_IN;
    logic                   DATA_VALID;
    logic                   DATA_READY;
    logic [LANES-1:0]       Q;
    logic                   BUSY;
    logic                   UNDERRUN;

    modport master (
        output DATA_IN,
        output DATA_VALID,
        input  DATA_READY,
        input  Q,
        input  BUSY,
        input  UNDERRUN
    );

    modport slave (
        input  DATA_IN,
        input  DATA_VALID,
        output DATA_READY,
        output Q,
        output BUSY,
        output UNDERRUN
    );
endinterface

// File: rtl/efx_oddr_lane.sv
// ---------------------------------------------------------------------------
// efx_oddr_lane
// Same-edge DDR output stage for one lane.
//   CLK : serial clock; rising edge captures d0/d1, Q muxes on CLK level
//   SR  : asynchronous active-high reset, all registers go to SR_VALUE
//   CE  : enable for the rising-edge registers
//   d0  : bit shown during the high phase following the edge
//   d1  : bit shown during the low phase following the edge
//   Q   : serial output
// ---------------------------------------------------------------------------
module efx_oddr_lane #(
    parameter bit SR_VALUE = 1'b0
) (
    input  logic CLK,
    input  logic SR,
    input  logic CE,
    input  logic d0,
    input  logic d1,
    output logic Q
);
    logic q0;
    logic q1_pre;
    logic q1;

    always_ff @(posedge CLK or posedge SR) begin
        if (SR) begin
            q0     <= SR_VALUE;
            q1_pre <= SR_VALUE;
        end else if (CE) begin
            q0     <= d0;
            q1_pre <= d1;
        end
    end

    // Retiming the odd bit onto the falling edge keeps the mux input stable
    // for the whole low phase; not gated by CE, so a frozen q1_pre just repeats.
    always_ff @(negedge CLK or posedge SR) begin
        if (SR) begin
            q1 <= SR_VALUE;
        end else begin
            q1 <= q1_pre;
        end
    end

    assign Q = CLK ? q0 : q1;

endmodule

// File: rtl/efx_oserdes_ddr.sv
// ---------------------------------------------------------------------------
// efx_oserdes_ddr
// Multi-lane DDR output serializer with a one-word holding buffer.
//   CLK : serial clock
//   SR  : asynchronous active-high reset
//   CE  : clock enable; when low every register holds
//   bus : slave side of efx_oserdes_ddr_if (word handshake, Q, BUSY, UNDERRUN)
// Each accepted word is sent two bits per CLK cycle per lane, even bit in the
// high phase, odd bit in the low phase. A word waiting in the holding buffer
// is loaded on the last beat of the current word so streaming is gapless.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | nothing on the lanes, Q = SR_VALUE
// ST_RUN  | a word is on the lanes, beat = index of the pair being shown
// ---------------------------------------------------------------------------
module efx_oserdes_ddr
    import efx_serdes_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int RATIO     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit SR_VALUE  = 1'b0
) (
    input  logic              CLK,
    input  logic              SR,
    input  logic              CE,
    efx_oserdes_ddr_if.slave  bus
);
    localparam int BEATS = beats_of(RATIO);
    localparam int BW    = beat_width(RATIO);
    localparam int WW    = LANES * RATIO;
    localparam int IW    = $clog2(WW);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    ser_state_t     state, state_nx;
    logic [BW-1:0]  beat, beat_nx;
    logic           hold_full, hold_full_nx;
    logic [WW-1:0]  hold_data, hold_data_nx;
    logic [WW-1:0]  shreg, shreg_nx;
    logic           underrun, underrun_nx;

    logic           accept;
    logic           load;
    logic           emit;
    logic [WW-1:0]  pair_word;
    logic [BW-1:0]  pair_idx;
    logic [LANES-1:0] q0_d;
    logic [LANES-1:0] q1_d;
    logic [LANES-1:0] q_lane;

    // Accept and load can never target the buffer together: accept needs it
    // empty, load needs it full.
    assign accept = CE && bus.DATA_VALID && !hold_full;
    assign load   = CE && hold_full && ((state == ST_IDLE) || (beat == LAST_BEAT));

    always_ff @(posedge CLK or posedge SR) begin
        if (SR) begin
            state     <= ST_IDLE;
            beat      <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
            shreg     <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nx;
            beat      <= beat_nx;
            hold_full <= hold_full_nx;
            hold_data <= hold_data_nx;
            shreg     <= shreg_nx;
            underrun  <= underrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        beat_nx      = beat;
        hold_full_nx = hold_full;
        hold_data_nx = hold_data;
        shreg_nx     = shreg;
        underrun_nx  = underrun;
        emit         = 1'b0;
        pair_word    = shreg;
        pair_idx     = beat;
        q0_d         = {LANES{SR_VALUE}};
        q1_d         = {LANES{SR_VALUE}};

        if (CE) begin
            underrun_nx = 1'b0;

            if (accept) begin
                hold_full_nx = 1'b1;
                hold_data_nx = bus.DATA_IN;
            end

            if (load) begin
                // First pair comes straight from the buffer, the rest from shreg.
                shreg_nx     = hold_data;
                hold_full_nx = 1'b0;
                beat_nx      = '0;
                state_nx     = ST_RUN;
                emit         = 1'b1;
                pair_word    = hold_data;
                pair_idx     = '0;
            end else if ((state == ST_RUN) && (beat != LAST_BEAT)) begin
                beat_nx  = beat + 1'b1;
                emit     = 1'b1;
                pair_idx = beat + 1'b1;
            end else if (state == ST_RUN) begin
                state_nx    = ST_IDLE;
                beat_nx     = '0;
                underrun_nx = 1'b1;
            end
        end

        if (emit) begin
            for (int l = 0; l < LANES; l++) begin
                q0_d[l] = pair_word[IW'(lane_base(l, RATIO)
                          + bit_index(int'(pair_idx), 0, MSB_FIRST, RATIO))];
                q1_d[l] = pair_word[IW'(lane_base(l, RATIO)
                          + bit_index(int'(pair_idx), 1, MSB_FIRST, RATIO))];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        efx_oddr_lane #(
            .SR_VALUE (SR_VALUE)
        ) u_lane (
            .CLK (CLK),
            .SR  (SR),
            .CE  (CE),
            .d0  (q0_d[l]),
            .d1  (q1_d[l]),
            .Q   (q_lane[l])
        );
    end

    // Ready drops with SR directly so the source sees no window during reset.
    assign bus.DATA_READY = !hold_full && !SR;
    assign bus.Q          = q_lane;
    assign bus.BUSY       = (state == ST_RUN);
    assign bus.UNDERRUN   = underrun;

endmodule

// File: tb/tb_efx_oserdes_ddr.sv
module tb_efx_oserdes_ddr;

    typedef struct {
        int which;   // 0: 2 lanes x 8 LSB-first, 1: 1 lane x 8 MSB-first, 2: 1 lane x 4
        int valid;
        int data;
        int ce;
        int rdy;
        int busy;
        int und;
        int hi;
        int lo;
    } vec_t;

    localparam int NV = 50;

    logic CLK = 1'b0;
    logic SR  = 1'b0;
    logic CE  = 1'b1;

    int n_err    = 0;
    int n_checks = 0;

    vec_t tbl [NV];

    efx_oserdes_ddr_if #(.LANES(2), .RATIO(8)) bus_a ();
    efx_oserdes_ddr_if #(.LANES(1), .RATIO(8)) bus_m ();
    efx_oserdes_ddr_if #(.LANES(1), .RATIO(4)) bus_r ();

    efx_oserdes_ddr #(.LANES(2), .RATIO(8), .MSB_FIRST(1'b0), .SR_VALUE(1'b0)) dut_a (
        .CLK (CLK), .SR (SR), .CE (CE), .bus (bus_a)
    );
    efx_oserdes_ddr #(.LANES(1), .RATIO(8), .MSB_FIRST(1'b1), .SR_VALUE(1'b1)) dut_m (
        .CLK (CLK), .SR (SR), .CE (CE), .bus (bus_m)
    );
    efx_oserdes_ddr #(.LANES(1), .RATIO(4), .MSB_FIRST(1'b0), .SR_VALUE(1'b0)) dut_r (
        .CLK (CLK), .SR (SR), .CE (CE), .bus (bus_r)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] get_rdy(input int w);
        case (w)
            0:       return 32'(bus_a.DATA_READY);
            1:       return 32'(bus_m.DATA_READY);
            default: return 32'(bus_r.DATA_READY);
        endcase
    endfunction

    function automatic logic [31:0] get_busy(input int w);
        case (w)
            0:       return 32'(bus_a.BUSY);
            1:       return 32'(bus_m.BUSY);
            default: return 32'(bus_r.BUSY);
        endcase
    endfunction

    function automatic logic [31:0] get_und(input int w);
        case (w)
            0:       return 32'(bus_a.UNDERRUN);
            1:       return 32'(bus_m.UNDERRUN);
            default: return 32'(bus_r.UNDERRUN);
        endcase
    endfunction

    function automatic logic [31:0] get_q(input int w);
        case (w)
            0:       return 32'(bus_a.Q);
            1:       return 32'(bus_m.Q);
            default: return 32'(bus_r.Q);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        CE               = (v.ce != 0);
        bus_a.DATA_VALID = (v.which == 0) && (v.valid != 0);
        bus_m.DATA_VALID = (v.which == 1) && (v.valid != 0);
        bus_r.DATA_VALID = (v.which == 2) && (v.valid != 0);
        bus_a.DATA_IN    = 16'(v.data);
        bus_m.DATA_IN    = 8'(v.data);
        bus_r.DATA_IN    = 4'(v.data);
    endtask

    // Entered just after a rising edge: checks the cycle that edge produced
    // (high phase, then low phase), then sets up inputs for the next edge.
    task automatic apply(input vec_t v, input int idx);
        #2;
        chk($sformatf("row%0d_ready", idx), get_rdy(v.which),  32'(v.rdy));
        chk($sformatf("row%0d_busy", idx),  get_busy(v.which), 32'(v.busy));
        chk($sformatf("row%0d_underrun", idx), get_und(v.which), 32'(v.und));
        chk($sformatf("row%0d_q_high", idx), get_q(v.which),   32'(v.hi));
        #5;
        chk($sformatf("row%0d_q_low", idx),  get_q(v.which),   32'(v.lo));
        drive(v);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            which valid data    ce  rdy busy und  hi     lo
        // single word, lane0=A5, lane1=3C, LSB first
        tbl[0]  = '{0, 1, 'h3CA5, 1,   1, 0, 0,  'b00, 'b00};
        tbl[1]  = '{0, 0, 0,      1,   0, 0, 0,  'b00, 'b00};
        tbl[2]  = '{0, 0, 0,      1,   1, 1, 0,  'b01, 'b00};
        tbl[3]  = '{0, 0, 0,      1,   1, 1, 0,  'b11, 'b10};
        tbl[4]  = '{0, 0, 0,      1,   1, 1, 0,  'b10, 'b11};
        tbl[5]  = '{0, 0, 0,      1,   1, 1, 0,  'b00, 'b01};
        tbl[6]  = '{0, 0, 0,      1,   1, 0, 1,  'b00, 'b00};
        tbl[7]  = '{0, 0, 0,      1,   1, 0, 0,  'b00, 'b00};
        // back-to-back: lane0 FF then 00, lane1 00 then FF
        tbl[8]  = '{0, 1, 'h00FF, 1,   1, 0, 0,  'b00, 'b00};
        tbl[9]  = '{0, 1, 'hFF00, 1,   0, 0, 0,  'b00, 'b00};
        tbl[10] = '{0, 1, 'hFF00, 1,   1, 1, 0,  'b01, 'b01};
        tbl[11] = '{0, 0, 0,      1,   0, 1, 0,  'b01, 'b01};
        tbl[12] = '{0, 0, 0,      1,   0, 1, 0,  'b01, 'b01};
        tbl[13] = '{0, 0, 0,      1,   0, 1, 0,  'b01, 'b01};
        tbl[14] = '{0, 0, 0,      1,   1, 1, 0,  'b10, 'b10};
        tbl[15] = '{0, 0, 0,      1,   1, 1, 0,  'b10, 'b10};
        tbl[16] = '{0, 0, 0,      1,   1, 1, 0,  'b10, 'b10};
        tbl[17] = '{0, 0, 0,      1,   1, 1, 0,  'b10, 'b10};
        tbl[18] = '{0, 0, 0,      1,   1, 0, 1,  'b00, 'b00};
        tbl[19] = '{0, 0, 0,      1,   1, 0, 0,  'b00, 'b00};
        // MSB first, word 80, idle level 1
        tbl[20] = '{1, 1, 'h80,   1,   1, 0, 0,  1, 1};
        tbl[21] = '{1, 0, 0,      1,   0, 0, 0,  1, 1};
        tbl[22] = '{1, 0, 0,      1,   1, 1, 0,  1, 0};
        tbl[23] = '{1, 0, 0,      1,   1, 1, 0,  0, 0};
        tbl[24] = '{1, 0, 0,      1,   1, 1, 0,  0, 0};
        tbl[25] = '{1, 0, 0,      1,   1, 1, 0,  0, 0};
        tbl[26] = '{1, 0, 0,      1,   1, 0, 1,  1, 1};
        tbl[27] = '{1, 0, 0,      1,   1, 0, 0,  1, 1};
        // RATIO=4 streaming: words 9, 6, C with VALID held high
        tbl[28] = '{2, 1, 'h9,    1,   1, 0, 0,  0, 0};
        tbl[29] = '{2, 1, 'h6,    1,   0, 0, 0,  0, 0};
        tbl[30] = '{2, 1, 'h6,    1,   1, 1, 0,  1, 0};
        tbl[31] = '{2, 1, 'hC,    1,   0, 1, 0,  0, 1};
        tbl[32] = '{2, 1, 'hC,    1,   1, 1, 0,  0, 1};
        tbl[33] = '{2, 0, 0,      1,   0, 1, 0,  1, 0};
        tbl[34] = '{2, 0, 0,      1,   1, 1, 0,  0, 0};
        tbl[35] = '{2, 0, 0,      1,   1, 1, 0,  1, 1};
        tbl[36] = '{2, 0, 0,      1,   1, 0, 1,  0, 0};
        tbl[37] = '{2, 0, 0,      1,   1, 0, 0,  0, 0};
        // CE low for 3 edges at beat 2 (VALID offered meanwhile), then CE low over UNDERRUN
        tbl[38] = '{0, 1, 'h3CA5, 1,   1, 0, 0,  'b00, 'b00};
        tbl[39] = '{0, 0, 0,      1,   0, 0, 0,  'b00, 'b00};
        tbl[40] = '{0, 0, 0,      1,   1, 1, 0,  'b01, 'b00};
        tbl[41] = '{0, 0, 0,      1,   1, 1, 0,  'b11, 'b10};
        tbl[42] = '{0, 1, 'h1234, 0,   1, 1, 0,  'b10, 'b11};
        tbl[43] = '{0, 1, 'h1234, 0,   1, 1, 0,  'b10, 'b11};
        tbl[44] = '{0, 1, 'h1234, 0,   1, 1, 0,  'b10, 'b11};
        tbl[45] = '{0, 0, 0,      1,   1, 1, 0,  'b10, 'b11};
        tbl[46] = '{0, 0, 0,      1,   1, 1, 0,  'b00, 'b01};
        tbl[47] = '{0, 0, 0,      0,   1, 0, 1,  'b00, 'b00};
        tbl[48] = '{0, 0, 0,      1,   1, 0, 1,  'b00, 'b00};
        tbl[49] = '{0, 0, 0,      1,   1, 0, 0,  'b00, 'b00};

        bus_a.DATA_VALID = 1'b0;
        bus_m.DATA_VALID = 1'b0;
        bus_r.DATA_VALID = 1'b0;
        bus_a.DATA_IN    = '0;
        bus_m.DATA_IN    = '0;
        bus_r.DATA_IN    = '0;
        CE               = 1'b1;

        // reset state
        #1 SR = 1'b1;
        @(posedge CLK);
        #3;
        chk("rst_ready_a",    32'(bus_a.DATA_READY), 32'd0);
        chk("rst_ready_m",    32'(bus_m.DATA_READY), 32'd0);
        chk("rst_busy_a",     32'(bus_a.BUSY),       32'd0);
        chk("rst_underrun_a", 32'(bus_a.UNDERRUN),   32'd0);
        chk("rst_q_high_a",   32'(bus_a.Q),          32'd0);
        chk("rst_q_high_m",   32'(bus_m.Q),          32'd1);
        @(negedge CLK);
        #3;
        chk("rst_q_low_a",    32'(bus_a.Q),          32'd0);
        chk("rst_q_low_m",    32'(bus_m.Q),          32'd1);
        @(posedge CLK);
        #1;
        SR = 1'b0;
        #1;
        chk("release_ready_a", 32'(bus_a.DATA_READY), 32'd1);
        chk("release_ready_r", 32'(bus_r.DATA_READY), 32'd1);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], i);
        end

        // SR mid-word at beat 2 with the holding buffer full
        apply('{0, 1, 'h3CA5, 1, 1, 0, 0, 'b00, 'b00}, 100);
        apply('{0, 1, 'h00FF, 1, 0, 0, 0, 'b00, 'b00}, 101);
        apply('{0, 1, 'h00FF, 1, 1, 1, 0, 'b01, 'b00}, 102);
        apply('{0, 0, 0,      1, 0, 1, 0, 'b11, 'b10}, 103);
        #2;
        chk("sr_pre_q_high", 32'(bus_a.Q), 32'b10);
        chk("sr_pre_ready",  32'(bus_a.DATA_READY), 32'd0);
        SR = 1'b1;
        #1;
        chk("sr_q_high",   32'(bus_a.Q),          32'd0);
        chk("sr_ready",    32'(bus_a.DATA_READY), 32'd0);
        chk("sr_busy",     32'(bus_a.BUSY),       32'd0);
        chk("sr_underrun", 32'(bus_a.UNDERRUN),   32'd0);
        @(negedge CLK);
        #2;
        chk("sr_q_low",    32'(bus_a.Q),          32'd0);
        @(posedge CLK);
        #1;
        SR = 1'b0;
        #1;
        chk("sr_release_ready", 32'(bus_a.DATA_READY), 32'd1);
        apply('{0, 0, 0, 1, 1, 0, 0, 'b00, 'b00}, 104);
        apply('{0, 0, 0, 1, 1, 0, 0, 'b00, 'b00}, 105);
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i], 110 + i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
